// File: rtl/run_sequencer_if.sv
// Handshake and status bundle between the bench/host side and the run sequencer.
interface run_sequencer_if #(
  parameter int CW = 10
);
  logic          start;
  logic          core_halt;
  logic          host_req;
  logic          core_reset;
  logic          core_en;
  logic          host_gnt;
  logic          mem_sel;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [7:0]    run_count;

  modport master (
    output start, core_halt, host_req,
    input  core_reset, core_en, host_gnt, mem_sel, done, timeout, cycle_count, run_count
  );

  modport slave (
    input  start, core_halt, host_req,
    output core_reset, core_en, host_gnt, mem_sel, done, timeout, cycle_count, run_count
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle core: launch on start falling edge, hold the core
// in reset, run it under a cycle watchdog, and arbitrate the data-memory port for the host.
module run_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int WATCHDOG    = 1000,
  parameter int CW          = 10
) (
  input logic            clk,
  input logic            reset,
  run_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WD_LIMIT  = CW'(WATCHDOG);

  logic [1:0]    state;
  logic          start_q;
  logic          pending;
  logic [HW-1:0] hold_cnt;
  logic          core_reset;
  logic          core_en;
  logic          host_gnt;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [7:0]    run_count;

  logic          launch_edge;
  logic          can_launch;
  logic [CW-1:0] count_inc;

  assign launch_edge = start_q & ~bus.start;
  assign can_launch  = ((state == IDLE) || (state == DONE)) && pending && !host_gnt;
  assign count_inc   = cycle_count + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      pending     <= 1'b0;
      hold_cnt    <= '0;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      host_gnt    <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      run_count   <= '0;
    end else begin
      start_q <= bus.start;
      case (state)
        IDLE, DONE: begin
          if (can_launch) begin
            state       <= HOLD;
            pending     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            hold_cnt    <= '0;
            core_reset  <= 1'b1;
            core_en     <= 1'b0;
          end else begin
            if (launch_edge) pending <= 1'b1;
            // A pending launch blocks new grants but lets an existing one run out.
            host_gnt <= bus.host_req && (host_gnt || !pending);
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
            core_en    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        RUN: begin
          cycle_count <= count_inc;
          // Halt takes priority over the watchdog when both land on the same cycle.
          if (bus.core_halt || (count_inc == WD_LIMIT)) begin
            state     <= DONE;
            core_en   <= 1'b0;
            done      <= 1'b1;
            timeout   <= !bus.core_halt;
            run_count <= run_count + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_reset  = core_reset;
  assign bus.core_en     = core_en;
  assign bus.host_gnt    = host_gnt;
  assign bus.mem_sel     = host_gnt;
  assign bus.done        = done;
  assign bus.timeout     = timeout;
  assign bus.cycle_count = cycle_count;
  assign bus.run_count   = run_count;

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Run controller for the single-cycle 9-bit core and its data memory. Turns the bench's `start` handshake into a core reset/run window and detects halt. Enforces a cycle watchdog and reports `done`, `timeout` and the run cycle count. Between runs, grants the host exclusive access to the data-memory port so operands can be loaded and results unloaded.

## Interface
- `HOLD_CYCLES`, default 2: cycles the core is held in reset after launch, minimum 1.
- `WATCHDOG`, default 1000: maximum number of RUN cycles before a forced stop.
- `CW`, default 10: width of the cycle counter; must satisfy 2^CW > WATCHDOG.
- `clk`  in  1  single clock; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch handshake from the bench; a run launches on its falling edge.
- `core_halt`  in  1  core reports a halt instruction or a stuck PC this cycle.
- `host_req`  in  1  host requests the data-memory port.
- `core_reset`  out  1  holds the core's PC and register file in reset.
- `core_en`  out  1  core is allowed to advance.
- `host_gnt`  out  1  host owns the data-memory port.
- `mem_sel`  out  1  data-memory mux select: 1 = host, 0 = core; always equal to `host_gnt`.
- `done`  out  1  last run has completed.
- `timeout`  out  1  last run was stopped by the watchdog.
- `cycle_count`  out  CW  number of cycles with `core_en`=1 in the last or current run.
- `run_count`  out  8  completed runs, wrapping.

## Operation
- The FSM has four states: IDLE, HOLD, RUN and DONE. All outputs are registered.
- Reset values:
  - state = IDLE
  - `core_reset`=1, `core_en`=0
  - `host_gnt`=`mem_sel`=0
  - `done`=0, `timeout`=0
  - `cycle_count`=0, `run_count`=0
  - internal `start_q`=0, `pending`=0
- Launch edge: `start_q`=1 and `start`=0 while in IDLE or DONE sets `pending`. Launch edges seen in HOLD or RUN are discarded.
- IDLE: `core_reset`=1, `core_en`=0.
- DONE: `core_reset`=0, `core_en`=0, so the core state stays frozen for inspection.
- Host arbitration (IDLE and DONE only): `host_gnt` takes the value of `host_req` on the next cycle. Once `pending`=1, `host_gnt` is no longer asserted anew, but an existing grant is held until `host_req` drops.
- IDLE/DONE to HOLD: taken when `pending`=1 and `host_gnt`=0. On this transition:
  - clear `pending`, `done`, `timeout` and `cycle_count`
  - drive `core_reset`=1
- HOLD: `core_reset`=1 for exactly HOLD_CYCLES cycles, then go to RUN.
- RUN:
  - `core_reset`=0, `core_en`=1, `host_gnt`=0.
  - `cycle_count` increments once per RUN cycle, including the cycle in which `core_halt` is seen.
  - `core_halt`=1 sends the FSM to DONE with `done`=1 and `timeout`=0.
  - If the incremented count equals WATCHDOG, go to DONE with `done`=1 and `timeout`=1.
  - If halt and watchdog occur in the same cycle, halt wins: `timeout`=0.
  - `host_req` during RUN is ignored; no grant is given until DONE.
- `run_count` increments on every entry to DONE and wraps from 255 to 0.
- `core_halt` is ignored outside RUN.
- Asserting `reset` in any state forces all reset values on the next edge and aborts a run in progress. `run_count` is not incremented for an aborted run.

## Timing
- Launch edge seen at cycle n: `pending`=1 at n+1.
- With no host grant held: HOLD at n+2, RUN at n+2+HOLD_CYCLES.
- `core_halt` sampled high at RUN cycle k (first RUN cycle is k=1):
  - `done`=1 and `cycle_count`=k on the next cycle
  - `core_en`=0 in that same cycle
- Watchdog: RUN lasts exactly WATCHDOG cycles; `done`=`timeout`=1 and `cycle_count`=WATCHDOG on the following cycle.
- Host grant latency: 1 cycle after `host_req` rises. The grant drops 1 cycle after `host_req` falls.
- Launch behind a held grant is delayed until 1 cycle after `host_gnt` falls.

## Test plan
- Reset, then pulse `start` 1→0 with `core_halt` raised on the 5th RUN cycle → `core_reset` high for exactly 2 cycles; `done`=1, `timeout`=0, `cycle_count`=5, `run_count`=1.
- Never raise `core_halt` (WATCHDOG=1000) → exactly 1000 cycles with `core_en`=1; then `done`=1, `timeout`=1, `cycle_count`=1000.
- Raise `core_halt` on RUN cycle 1000 → `timeout`=0, `cycle_count`=1000.
- Hold `host_req`=1 in IDLE, launch, drop `host_req` 6 cycles later:
  - `host_gnt` rises 1 cycle after request
  - HOLD entered 1 cycle after `host_gnt` falls
  - `mem_sel` tracks `host_gnt` throughout
- Pulse `host_req` and a second `start` edge during RUN → no grant, no relaunch; grant appears 1 cycle after DONE if `host_req` is still high.
- Assert `reset` at RUN cycle 3 → next cycle shows IDLE and all reset values, `run_count` unchanged at 0; a fresh launch then completes normally. Separately, run 256 completions → `run_count` wraps to 0.
